// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared types and constants for the multiplier arbiter
package mul_arb_pkg;

  localparam int NREQ = 2;

  typedef logic [2:0] mul_funct3_t;

  localparam mul_funct3_t MUL_OP_MUL    = 3'b000;
  localparam mul_funct3_t MUL_OP_MULH   = 3'b001;
  localparam mul_funct3_t MUL_OP_MULHSU = 3'b010;
  localparam mul_funct3_t MUL_OP_MULHU  = 3'b011;

endpackage

// File: rtl/mul_arb_rr_arb2.sv
// rtl/mul_arb_rr_arb2.sv - two-way round-robin grant with pointer update on accept
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       next_ptr
);

  // pick the pointed-to requester on contention, else the lone valid one;
  // the pointer only moves when a contended grant is actually taken
  always_comb begin
    grant    = valid;
    next_ptr = ptr;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
      if (enable) next_ptr = ~ptr;
    end
  end

endmodule

// File: rtl/mul_arb.sv
// rtl/mul_arb.sv - shares one 2-stage multiplier between two requesters (optional MUL_ARB_PERF_EN counters)
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     ReqValid,
  output logic [NREQ-1:0]     ReqReady,
  input  logic [2*XLEN-1:0]   ReqSrcA,
  input  logic [2*XLEN-1:0]   ReqSrcB,
  input  logic [5:0]          ReqFunct3,
  input  logic                Flush,
  output logic [XLEN-1:0]     MulSrcAE,
  output logic [XLEN-1:0]     MulSrcBE,
  output logic [2:0]          MulFunct3E,
  output logic                MulStallM,
  output logic                MulFlushM,
  input  logic [2*XLEN-1:0]   MulProdM,
  output logic [NREQ-1:0]     RspValid,
  output logic [2*XLEN-1:0]   RspProd,
  input  logic                RspReady
`ifdef MUL_ARB_PERF_EN
  ,
  output logic [31:0]         PerfGrant0,
  output logic [31:0]         PerfGrant1,
  output logic [31:0]         PerfStall
`endif
);

  logic        mvalid;
  logic        mtag;
  logic        rrptr;

  logic        blocked;
  logic        can_issue;
  logic        issue;
  logic [1:0]  grant;
  logic        next_ptr;
  logic        sel;
  logic        rsp_live;
  mul_funct3_t funct_sel;

  assign blocked   = mvalid & ~RspReady;
  assign can_issue = ~blocked & ~Flush & reset;

  rr_arb2 u_rr_arb2 (
    .valid    (ReqValid),
    .ptr      (rrptr),
    .enable   (issue),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign ReqReady = grant & {2{can_issue}};
  assign issue    = |ReqReady;

  // operand steering: granted requester, or the priority holder when idle
  always_comb begin
    sel       = (grant != 2'b00) ? grant[1] : rrptr;
    MulSrcAE  = sel ? ReqSrcA[2*XLEN-1:XLEN] : ReqSrcA[XLEN-1:0];
    MulSrcBE  = sel ? ReqSrcB[2*XLEN-1:XLEN] : ReqSrcB[XLEN-1:0];
    funct_sel = sel ? ReqFunct3[5:3] : ReqFunct3[2:0];
    MulFunct3E = funct_sel;
  end

  // a flushed op is never presented, even in the cycle the flush arrives
  assign rsp_live  = mvalid & ~Flush & reset;
  assign RspValid  = {rsp_live & mtag, rsp_live & ~mtag};
  assign RspProd   = MulProdM;
  assign MulStallM = blocked & reset;
  assign MulFlushM = Flush | ~reset | (~blocked & ~issue);

  // M-stage occupancy, owner tag and round-robin pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mvalid <= 1'b0;
      mtag   <= 1'b0;
      rrptr  <= 1'b0;
    end else begin
      rrptr <= next_ptr;
      if (Flush) begin
        mvalid <= 1'b0;
      end else if (!blocked) begin
        mvalid <= issue;
        if (issue) mtag <= grant[1];
      end
    end
  end

`ifdef MUL_ARB_PERF_EN
  // free-running accept and stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PerfGrant0 <= '0;
      PerfGrant1 <= '0;
      PerfStall  <= '0;
    end else begin
      if (ReqValid[0] & ReqReady[0]) PerfGrant0 <= PerfGrant0 + 32'd1;
      if (ReqValid[1] & ReqReady[1]) PerfGrant1 <= PerfGrant1 + 32'd1;
      if (blocked)                   PerfStall  <= PerfStall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_arb.sv
// tb/tb_mul_arb.sv - scoreboard bench for mul_arb with a behavioural two-stage multiplier
module tb_mul_arb;

  localparam int XLEN = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       ReqValid;
  logic [1:0]       ReqReady;
  logic [127:0]     ReqSrcA;
  logic [127:0]     ReqSrcB;
  logic [5:0]       ReqFunct3;
  logic             Flush;
  logic [63:0]      MulSrcAE;
  logic [63:0]      MulSrcBE;
  logic [2:0]       MulFunct3E;
  logic             MulStallM;
  logic             MulFlushM;
  logic [127:0]     MulProdM;
  logic [1:0]       RspValid;
  logic [127:0]     RspProd;
  logic             RspReady;
`ifdef MUL_ARB_PERF_EN
  logic [31:0]      PerfGrant0;
  logic [31:0]      PerfGrant1;
  logic [31:0]      PerfStall;
`endif

  mul_arb #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqSrcA    (ReqSrcA),
    .ReqSrcB    (ReqSrcB),
    .ReqFunct3  (ReqFunct3),
    .Flush      (Flush),
    .MulSrcAE   (MulSrcAE),
    .MulSrcBE   (MulSrcBE),
    .MulFunct3E (MulFunct3E),
    .MulStallM  (MulStallM),
    .MulFlushM  (MulFlushM),
    .MulProdM   (MulProdM),
    .RspValid   (RspValid),
    .RspProd    (RspProd),
    .RspReady   (RspReady)
`ifdef MUL_ARB_PERF_EN
    ,
    .PerfGrant0 (PerfGrant0),
    .PerfGrant1 (PerfGrant1),
    .PerfStall  (PerfStall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         tag;
    logic [127:0] prod;
  } exp_t;

  exp_t         sb_q[$];
  logic [127:0] exp0;
  logic [127:0] exp1;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] mulf(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic         sa;
    logic         sb;
    logic [127:0] ea;
    logic [127:0] eb;
    sa = (f != 3'b011);
    sb = (f == 3'b000) || (f == 3'b001);
    ea = {{64{sa & a[63]}}, a};
    eb = {{64{sb & b[63]}}, b};
    return ea * eb;
  endfunction

  // external multiplier: E operands captured into M, honouring stall and flush
  always @(posedge clk or negedge reset) begin
    if (!reset)          MulProdM <= '0;
    else if (MulFlushM)  MulProdM <= '0;
    else if (!MulStallM) MulProdM <= mulf(MulFunct3E, MulSrcAE, MulSrcBE);
  end

  // stimulus side: every observed accept pushes the hand-computed product
  always @(negedge clk) begin
    if (reset) begin
      if (Flush) sb_q.delete();
      if (ReqValid[0] & ReqReady[0]) sb_q.push_back('{tag: 1'b0, prod: exp0});
      if (ReqValid[1] & ReqReady[1]) sb_q.push_back('{tag: 1'b1, prod: exp1});
    end
  end

  // monitor: each completed response is checked against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset && RspValid != 2'b00 && RspReady) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {126'd0, RspValid}, 128'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_owner", {126'd0, RspValid}, e.tag ? 128'd2 : 128'd1);
        chk("rsp_prod", RspProd, e.prod);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f);
    ReqSrcA[63:0] = a;
    ReqSrcB[63:0] = b;
    ReqFunct3[2:0] = f;
  endtask

  task automatic set1(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f);
    ReqSrcA[127:64] = a;
    ReqSrcB[127:64] = b;
    ReqFunct3[5:3] = f;
  endtask

  initial begin
    ReqValid  = 2'b11;
    ReqSrcA   = '0;
    ReqSrcB   = '0;
    ReqFunct3 = '0;
    Flush     = 1'b0;
    RspReady  = 1'b1;
    exp0      = '0;
    exp1      = '0;

    #2;
    chk("rst_rspvalid", {126'd0, RspValid}, 128'd0);
    chk("rst_reqready", {126'd0, ReqReady}, 128'd0);
    chk("rst_stall", {127'd0, MulStallM}, 128'd0);
    chk("rst_flushm", {127'd0, MulFlushM}, 128'd1);
    cyc();
    cyc();
    reset    = 1'b1;
    ReqValid = 2'b00;
    cyc();

    // single requester, 3*5
    set0(64'd3, 64'd5, 3'b000);
    exp0 = 128'd15;
    ReqValid = 2'b01;
    @(negedge clk); chk("t1_reqready", {126'd0, ReqReady}, 128'd1);
    cyc();
    ReqValid = 2'b00;
    @(negedge clk);
    chk("t1_rspvalid", {126'd0, RspValid}, 128'd1);
    chk("t1_rspprod", RspProd, 128'd15);
    cyc();
    @(negedge clk);
    chk("t1_idle_valid", {126'd0, RspValid}, 128'd0);
    chk("t1_idle_prod", RspProd, 128'd0);
    cyc();

    // contention: grants alternate 0,1,0,1
    set0(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 3'b001);
    exp0 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA;
    set1(64'h8000_0000_0000_0000, 64'd2, 3'b011);
    exp1 = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
    ReqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_grant", {126'd0, ReqReady}, (i % 2 == 1) ? 128'd2 : 128'd1);
      cyc();
    end
    ReqValid = 2'b00;
    cyc();
    cyc();

    // backpressure for three cycles, then delivery and accept on one edge
    set0(64'd7, 64'd6, 3'b000);
    exp0 = 128'd42;
    ReqValid = 2'b01;
    @(negedge clk); chk("t3_accept", {126'd0, ReqReady}, 128'd1);
    cyc();
    set1(64'd4, 64'd4, 3'b000);
    exp1 = 128'd16;
    ReqValid = 2'b10;
    RspReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall", {127'd0, MulStallM}, 128'd1);
      chk("t3_reqready", {126'd0, ReqReady}, 128'd0);
      chk("t3_rspvalid", {126'd0, RspValid}, 128'd1);
      chk("t3_rspprod", RspProd, 128'd42);
      cyc();
    end
    RspReady = 1'b1;
    @(negedge clk);
    chk("t3_resume_ready", {126'd0, ReqReady}, 128'd2);
    chk("t3_resume_valid", {126'd0, RspValid}, 128'd1);
    cyc();
    ReqValid = 2'b00;
    @(negedge clk);
    chk("t3_next_valid", {126'd0, RspValid}, 128'd2);
    chk("t3_next_prod", RspProd, 128'd16);
    cyc();
    cyc();

    // flush the cycle after an accept
    set0(64'd9, 64'd9, 3'b000);
    exp0 = 128'd81;
    ReqValid = 2'b01;
    @(negedge clk); chk("t4_accept", {126'd0, ReqReady}, 128'd1);
    cyc();
    Flush = 1'b1;
    @(negedge clk);
    chk("t4_flush_ready", {126'd0, ReqReady}, 128'd0);
    chk("t4_flush_valid", {126'd0, RspValid}, 128'd0);
    chk("t4_flush_m", {127'd0, MulFlushM}, 128'd1);
    cyc();
    Flush = 1'b0;
    ReqValid = 2'b00;
    @(negedge clk);
    chk("t4_after_valid", {126'd0, RspValid}, 128'd0);
    chk("t4_after_prod", RspProd, 128'd0);
    cyc();

`ifdef MUL_ARB_PERF_EN
    chk("perf_grant0", {96'd0, PerfGrant0}, 128'd5);
    chk("perf_grant1", {96'd0, PerfGrant1}, 128'd3);
    chk("perf_stall", {96'd0, PerfStall}, 128'd3);
`endif

    // asynchronous reset mid-operation, pointer left at 1 beforehand
    set0(64'd5, 64'd5, 3'b000);
    exp0 = 128'd25;
    set1(64'd6, 64'd6, 3'b000);
    exp1 = 128'd36;
    ReqValid = 2'b11;
    @(negedge clk); chk("t5_grant", {126'd0, ReqReady}, 128'd1);
    cyc();
    #1;
    chk("t5_inflight", {126'd0, RspValid}, 128'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", {126'd0, RspValid}, 128'd0);
    chk("t5_rst_ready", {126'd0, ReqReady}, 128'd0);
    sb_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ptr_reset", {126'd0, ReqReady}, 128'd1);
    chk("t5_idle_valid", {126'd0, RspValid}, 128'd0);
    cyc();
    ReqValid = 2'b00;
    @(negedge clk);
    chk("t5_rsp_valid", {126'd0, RspValid}, 128'd1);
    cyc();
    cyc();

    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
